// File: rtl/dds_pkg.sv
// dds_pkg: types and constants shared by the sweep controller and the DDS core.
//   sweep_state_e : sweep controller states (DOWN is only reachable when the
//                   controller is built with DDS_SWEEP_TRI_EN)
//   DDS_PW_DEF    : default phase/frequency word width
//   tuning_word_t : signed tuning word at the default width
package dds_pkg;

  localparam int DDS_PW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DOWN = 2'd2,
    FIN  = 2'd3
  } sweep_state_e;

  typedef logic signed [DDS_PW_DEF-1:0] tuning_word_t;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped linear frequency-sweep controller driving a DDS core.
//
// On an accepted start (IDLE only) the configuration is latched and the
// controller presents f_start, f_start+f_step, ... for dwell+1 cycles each,
// covering n_steps+1 frequencies, then pulses done for one cycle.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   start     one-cycle sweep request, honoured only in IDLE
//   abort     return to IDLE from any state (wins over start)
//   tri_mode  (DDS_SWEEP_TRI_EN only) triangle sweep: ramp back down to
//             f_start after the peak, latched at start
//   f_start   signed start tuning word
//   f_step    signed per-step increment (negative = down-sweep)
//   n_steps   number of increments
//   dwell     cycles per frequency minus 1
//   ph_ofs    signed phase offset, latched at start
//   freq      tuning word to the DDS
//   phase     phase offset to the DDS
//   dds_en    DDS enable, identical to busy
//   busy      sweep in progress
//   done      one-cycle pulse on normal completion
//   step_idx  current frequency index
//
// Build option: define DDS_SWEEP_TRI_EN to add the tri_mode input and the
// DOWN state.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold last values
// RUN   | up-ramp: dwell on each frequency, then step by +f_step
// DOWN  | down-ramp after the peak (triangle mode only)
// FIN   | done pulse cycle; freq/phase/step_idx hold final values
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PW = DDS_PW_DEF,
  parameter int NW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
`ifdef DDS_SWEEP_TRI_EN
  input  logic                 tri_mode,
`endif
  input  logic signed [PW-1:0] f_start,
  input  logic signed [PW-1:0] f_step,
  input  logic        [NW-1:0] n_steps,
  input  logic        [NW-1:0] dwell,
  input  logic signed [PW-1:0] ph_ofs,
  output logic signed [PW-1:0] freq,
  output logic signed [PW-1:0] phase,
  output logic                 dds_en,
  output logic                 busy,
  output logic                 done,
  output logic        [NW-1:0] step_idx
);

  localparam logic [NW-1:0] ONE_NW = NW'(1);

  sweep_state_e        state_q, state_d;
  logic signed [PW-1:0] freq_q, freq_d;
  logic signed [PW-1:0] phase_q, phase_d;
  logic signed [PW-1:0] f_step_q, f_step_d;
  logic        [NW-1:0] step_idx_q, step_idx_d;
  logic        [NW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic        [NW-1:0] n_steps_q, n_steps_d;
  logic        [NW-1:0] dwell_q, dwell_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef DDS_SWEEP_TRI_EN
  logic                 tri_q, tri_d;
`endif

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    phase_d     = phase_q;
    f_step_d    = f_step_q;
    step_idx_d  = step_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    n_steps_d   = n_steps_q;
    dwell_d     = dwell_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef DDS_SWEEP_TRI_EN
    tri_d       = tri_q;
`endif

    if (abort) begin
      // phase deliberately keeps its value across an abort
      state_d     = IDLE;
      busy_d      = 1'b0;
      freq_d      = '0;
      step_idx_d  = '0;
      dwell_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = RUN;
            freq_d      = f_start;
            phase_d     = ph_ofs;
            f_step_d    = f_step;
            n_steps_d   = n_steps;
            dwell_d     = dwell;
            step_idx_d  = '0;
            dwell_cnt_d = '0;
            busy_d      = 1'b1;
`ifdef DDS_SWEEP_TRI_EN
            tri_d       = tri_mode;
`endif
          end
        end

        RUN: begin
          if (dwell_cnt_q != dwell_q) begin
            dwell_cnt_d = dwell_cnt_q + ONE_NW;
          end else if (step_idx_q == n_steps_q) begin
`ifdef DDS_SWEEP_TRI_EN
            // with n_steps=0 the peak is also the start point, so no ramp down
            if (tri_q && (n_steps_q != '0)) begin
              state_d     = DOWN;
              freq_d      = freq_q - f_step_q;
              step_idx_d  = step_idx_q - ONE_NW;
              dwell_cnt_d = '0;
            end else
`endif
            begin
              state_d = FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            freq_d      = freq_q + f_step_q;
            step_idx_d  = step_idx_q + ONE_NW;
            dwell_cnt_d = '0;
          end
        end

`ifdef DDS_SWEEP_TRI_EN
        DOWN: begin
          if (dwell_cnt_q != dwell_q) begin
            dwell_cnt_d = dwell_cnt_q + ONE_NW;
          end else if (step_idx_q == '0) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            freq_d      = freq_q - f_step_q;
            step_idx_d  = step_idx_q - ONE_NW;
            dwell_cnt_d = '0;
          end
        end
`endif

        FIN: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      freq_q      <= '0;
      phase_q     <= '0;
      f_step_q    <= '0;
      step_idx_q  <= '0;
      dwell_cnt_q <= '0;
      n_steps_q   <= '0;
      dwell_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DDS_SWEEP_TRI_EN
      tri_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
      f_step_q    <= f_step_d;
      step_idx_q  <= step_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      n_steps_q   <= n_steps_d;
      dwell_q     <= dwell_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DDS_SWEEP_TRI_EN
      tri_q       <= tri_d;
`endif
    end
  end

  assign freq     = freq_q;
  assign phase    = phase_q;
  assign busy     = busy_q;
  assign dds_en   = busy_q;
  assign done     = done_q;
  assign step_idx = step_idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: self-checking bench for dds_sweep_ctrl.
// The reference model lists the expected (frequency, index) for every busy
// cycle directly from the sweep definition: f_start + k*f_step held for
// dwell+1 cycles, k = 0..n_steps (and back down in triangle mode).
module tb_dds_sweep_ctrl;

  localparam int PW = 32;
  localparam int NW = 16;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 abort;
`ifdef DDS_SWEEP_TRI_EN
  logic                 tri_mode;
`endif
  logic        [PW-1:0] f_start;
  logic        [PW-1:0] f_step;
  logic        [NW-1:0] n_steps;
  logic        [NW-1:0] dwell;
  logic        [PW-1:0] ph_ofs;
  logic signed [PW-1:0] freq;
  logic signed [PW-1:0] phase;
  logic                 dds_en;
  logic                 busy;
  logic                 done;
  logic        [NW-1:0] step_idx;

  dds_sweep_ctrl #(.PW(PW), .NW(NW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
`ifdef DDS_SWEEP_TRI_EN
    .tri_mode (tri_mode),
`endif
    .f_start  (f_start),
    .f_step   (f_step),
    .n_steps  (n_steps),
    .dwell    (dwell),
    .ph_ofs   (ph_ofs),
    .freq     (freq),
    .phase    (phase),
    .dds_en   (dds_en),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] exp_f[$];
  logic [NW-1:0] exp_i[$];
  logic [PW-1:0] exp_phase;

  task automatic build_model(input logic [PW-1:0] fs, input logic [PW-1:0] fst,
                             input int n, input int d, input bit t);
    logic [PW-1:0] kk;
    exp_f.delete();
    exp_i.delete();
    for (int k = 0; k <= n; k++) begin
      kk = PW'(k);
      for (int r = 0; r <= d; r++) begin
        exp_f.push_back(fs + kk * fst);
        exp_i.push_back(NW'(k));
      end
    end
    if (t) begin
      for (int k = n - 1; k >= 0; k--) begin
        kk = PW'(k);
        for (int r = 0; r <= d; r++) begin
          exp_f.push_back(fs + kk * fst);
          exp_i.push_back(NW'(k));
        end
      end
    end
  endtask

  task automatic scramble_inputs();
    f_start = $urandom;
    f_step  = $urandom;
    n_steps = NW'($urandom);
    dwell   = NW'($urandom);
    ph_ofs  = $urandom;
`ifdef DDS_SWEEP_TRI_EN
    tri_mode = $urandom_range(0, 1) == 1;
`endif
  endtask

  // Runs one full sweep and checks every cycle, the done cycle and the
  // following idle cycle. poke=1 fires extra start pulses while busy/FIN.
  task automatic test_sweep(input string name, input logic [PW-1:0] fs,
                            input logic [PW-1:0] fst, input logic [PW-1:0] ph,
                            input int n, input int d, input bit t, input bit poke);
    logic [PW-1:0] last_f;
    logic [NW-1:0] last_i;
    build_model(fs, fst, n, d, t);
    @(negedge clk);
    f_start = fs;
    f_step  = fst;
    n_steps = NW'(n);
    dwell   = NW'(d);
    ph_ofs  = ph;
`ifdef DDS_SWEEP_TRI_EN
    tri_mode = t;
`endif
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < exp_f.size(); c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if ({busy, dds_en, done, freq, phase, step_idx} !==
          {1'b1, 1'b1, 1'b0, exp_f[c], ph, exp_i[c]}) begin
        n_err++;
        $display("FAIL %s cycle %0d: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want 1 1 0 freq=%h phase=%h idx=%0d",
                 name, c, busy, dds_en, done, freq, phase, step_idx, exp_f[c], ph, exp_i[c]);
      end
      scramble_inputs();
      start = poke && ($urandom_range(0, 3) == 0);
    end
    last_f = exp_f[exp_f.size()-1];
    last_i = exp_i[exp_i.size()-1];
    @(posedge clk);
    #1;
    start = poke;
    n_cmp++;
    if ({busy, dds_en, done, freq, phase, step_idx} !== {1'b0, 1'b0, 1'b1, last_f, ph, last_i}) begin
      n_err++;
      $display("FAIL %s done: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want 0 0 1 freq=%h phase=%h idx=%0d",
               name, busy, dds_en, done, freq, phase, step_idx, last_f, ph, last_i);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if ({busy, dds_en, done, freq, phase, step_idx} !== {1'b0, 1'b0, 1'b0, last_f, ph, last_i}) begin
      n_err++;
      $display("FAIL %s idle: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want 0 0 0 freq=%h phase=%h idx=%0d",
               name, busy, dds_en, done, freq, phase, step_idx, last_f, ph, last_i);
    end
    exp_phase = ph;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    scramble_inputs();
    #12;
    n_cmp++;
    if ({busy, dds_en, done, freq, phase, step_idx} !== {3'b000, {PW{1'b0}}, {PW{1'b0}}, {NW{1'b0}}}) begin
      n_err++;
      $display("FAIL reset: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want all zero",
               busy, dds_en, done, freq, phase, step_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_phase = '0;
  endtask

  task automatic test_abort();
    logic [PW-1:0] fs;
    logic [PW-1:0] fst;
    logic [PW-1:0] ph;
    fs  = $urandom;
    fst = $urandom;
    ph  = $urandom;
    @(negedge clk);
    f_start = fs;
    f_step  = fst;
    n_steps = 16'd4;
    dwell   = 16'd0;
    ph_ofs  = ph;
`ifdef DDS_SWEEP_TRI_EN
    tri_mode = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (freq !== fs + PW'(k) * fst || step_idx !== NW'(k) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL abort_pre k=%0d: got freq=%h idx=%0d busy=%b, want freq=%h idx=%0d busy=1",
                 k, freq, step_idx, busy, fs + PW'(k) * fst, k);
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_cmp++;
    if ({busy, dds_en, done, freq, phase, step_idx} !== {3'b000, {PW{1'b0}}, ph, {NW{1'b0}}}) begin
      n_err++;
      $display("FAIL abort: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want 0 0 0 freq=0 phase=%h idx=0",
               busy, dds_en, done, freq, phase, step_idx, ph);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_no_done: got busy=%b done=%b, want 0 0", busy, done);
    end
    exp_phase = ph;
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    scramble_inputs();
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if ({busy, dds_en, done, freq, phase, step_idx} !== {3'b000, {PW{1'b0}}, exp_phase, {NW{1'b0}}}) begin
        n_err++;
        $display("FAIL start_abort c=%0d: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want 0 0 0 freq=0 phase=%h idx=0",
                 c, busy, dds_en, done, freq, phase, step_idx, exp_phase);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    f_start = 32'h1234_5678;
    f_step  = 32'h0000_1000;
    n_steps = 16'd5;
    dwell   = 16'd2;
    ph_ofs  = 32'hCAFE_0001;
`ifdef DDS_SWEEP_TRI_EN
    tri_mode = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, dds_en, done, freq, phase, step_idx} !== {3'b000, {PW{1'b0}}, {PW{1'b0}}, {NW{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b en=%b done=%b freq=%h phase=%h idx=%0d, want all zero",
               busy, dds_en, done, freq, phase, step_idx);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_hold: got busy=%b done=%b, want 0 0", busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_phase = '0;
    test_sweep("after_reset", 32'h2000_0000, 32'h0010_0000, 32'h0000_00AA, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      test_sweep($sformatf("random%0d", r), $urandom, $urandom, $urandom,
                 $urandom_range(0, 5), $urandom_range(0, 3), 1'b0, 1'b1);
    end
  endtask

`ifdef DDS_SWEEP_TRI_EN
  task automatic test_triangle();
    test_sweep("tri_basic", 32'h0, 32'h10, 32'h0, 2, 0, 1'b1, 1'b0);
    test_sweep("tri_single", $urandom, $urandom, $urandom, 0, 2, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      test_sweep($sformatf("tri_random%0d", r), $urandom, $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 2), 1'b1, 1'b1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep("basic_up", 32'h1000_0000, 32'h0100_0000, 32'h0000_1234, 3, 1, 1'b0, 1'b0);
    test_sweep("wrap_up", 32'hFF00_0000, 32'h0100_0000, 32'h5555_0000, 2, 0, 1'b0, 1'b0);
    test_sweep("neg_step", 32'h0000_0000, 32'hFF00_0000, 32'h8000_0000, 2, 0, 1'b0, 1'b0);
    test_sweep("degenerate", 32'h0ABC_DEF0, 32'h0000_0100, 32'h7777_7777, 0, 0, 1'b0, 1'b1);
    test_sweep("busy_start", 32'h0000_0040, 32'h0000_0008, 32'h0000_0001, 4, 2, 1'b0, 1'b1);
    test_abort();
    test_start_abort_idle();
    test_reset_mid_sweep();
    test_random();
`ifdef DDS_SWEEP_TRI_EN
    test_triangle();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
